rca_chunk_adder: RTL and testbench
==================================

RCA_CHUNK_ADDER -- requirements
Module: rca_chunk_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits; SHALL be at least 2.
REQ-002 Parameter CHUNK, default 4: bits added per cycle; SHALL divide WIDTH exactly. N = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operands valid.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in (add) or borrow-in (subtract).
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 carry  output  1  carry-out of the final chunk.
REQ-015 overflow  output  1  two's-complement overflow flag.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DONE.
REQ-017 IDLE: in_ready=1 and out_valid=0; on in_valid=1 the block SHALL capture operands, clear chunk index k to 0 and go to RUN.
REQ-018 Capture: add -> A=a, B=b, c0=cin. Subtract -> A=a, B=~b, c0=~cin, so the result is a-b-cin.
REQ-019 RUN: each cycle SHALL add chunk k (bits k*CHUNK..k*CHUNK+CHUNK-1, LSB chunk first) of A and B plus the running carry, store the CHUNK result bits, and register the chunk carry-out as the next running carry.
REQ-020 RUN SHALL last exactly N cycles; after the cycle with k=N-1 the block SHALL go to DONE.
REQ-021 Latency: out_valid SHALL rise exactly N cycles after the accepting edge.
REQ-022 On entry to DONE: sum = full result mod 2^WIDTH; carry = raw carry-out of bit WIDTH-1 (subtract: 1 = no borrow); overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-023 DONE: out_valid=1 and in_ready=0; sum, carry and overflow SHALL stay stable until out_ready=1.
REQ-024 In DONE with out_ready=1, the block SHALL return to IDLE at that edge; a new operation SHALL NOT be accepted in the same cycle.
REQ-025 in_ready SHALL be 0 throughout RUN and DONE; a, b, cin, sub and in_valid SHALL be ignored there.
REQ-026 sum, carry and overflow SHALL hold the last result in IDLE and RUN until the next DONE entry. Mid-computation partial sums SHALL NOT appear on sum.
REQ-027 With CHUNK=WIDTH (N=1), the same FSM SHALL apply and latency SHALL be 1.

Reset
REQ-028 With rst=1 at a clock edge, the block SHALL enter IDLE. In the next cycle: in_ready=1, out_valid=0, sum=0, carry=0, overflow=0, k=0, running carry=0.
REQ-029 rst SHALL take priority over all other inputs in every state, including mid-RUN and DONE; the in-flight operation SHALL be discarded with no out_valid pulse.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-030 a=0xFFFF, b=0x0001, cin=0, sub=0 accepted at edge T -> out_valid at T+4; sum=0x0000, carry=1, overflow=0.
REQ-031 a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, carry=0, overflow=1.
REQ-032 a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, carry=0, overflow=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, carry=1, overflow=1.
REQ-033 out_ready held 0 for 3 cycles after out_valid -> out_valid, sum and carry stay stable and in_ready=0 throughout. Then out_ready=1 -> next cycle out_valid=0, in_ready=1.
REQ-034 rst=1 in the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0, and out_valid stays 0 while in_valid=0. A following 0x1234+0x1111 -> sum=0x2345 at 4-cycle latency.
REQ-035 WIDTH=8, CHUNK=8: a=0x80, b=0x80, cin=1 -> out_valid 1 cycle after accept; sum=0x01, carry=1, overflow=1.

Source files
------------

// File: rtl/rca_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : rca_chunk_adder
// Brief    : Multi-cycle ripple-carry adder/subtractor. Adds CHUNK bits per
//            cycle, LSB chunk first, with a valid/ready handshake on both
//            sides and carry/overflow flags on the final result.
// Revision : 1.0  initial release
// ============================================================================
module rca_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int c_N  = WIDTH / CHUNK;
    // Chunk index register is wide enough to also hold a bit offset up to WIDTH
    localparam int c_KW = $clog2(WIDTH + 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Reject parameterisations the chunked datapath cannot represent
    if ((WIDTH < 2) || (CHUNK < 1) || (c_N * CHUNK != WIDTH)) begin : g_param_check
        $error("rca_chunk_adder: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    logic [1:0]       r_state;
    logic [c_KW-1:0]  r_k;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_c;
    logic [WIDTH-1:0] r_acc;

    logic [c_KW-1:0]  w_base;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_chunk_sum;
    logic             w_c_out;
    logic             w_c_top_in;
    logic [WIDTH-1:0] w_full;
    logic             w_last;

    // Ripple one chunk of the stored operands; also track the carry entering
    // the chunk's top bit, which becomes the MSB carry-in on the last chunk
    always_comb begin
        w_base      = r_k * c_KW'(CHUNK);
        w_a_chunk   = r_op_a[w_base +: CHUNK];
        w_b_chunk   = r_op_b[w_base +: CHUNK];
        w_chunk_sum = '0;
        w_c_out     = r_c;
        w_c_top_in  = r_c;
        for (int i = 0; i < CHUNK; i++) begin
            w_c_top_in     = w_c_out;
            w_chunk_sum[i] = w_a_chunk[i] ^ w_b_chunk[i] ^ w_c_out;
            w_c_out        = (w_a_chunk[i] & w_b_chunk[i]) |
                             (w_a_chunk[i] & w_c_out)      |
                             (w_b_chunk[i] & w_c_out);
        end
        w_full                  = r_acc;
        w_full[w_base +: CHUNK] = w_chunk_sum;
        w_last                  = (r_k == c_KW'(c_N - 1));
    end

    // Control FSM and datapath; partial sums live in r_acc and only reach
    // the sum output when the final chunk completes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_k      <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_c      <= 1'b0;
            r_acc    <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_op_a  <= a;
                        r_op_b  <= sub ? ~b : b;
                        r_c     <= sub ? ~cin : cin;
                        r_k     <= '0;
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    r_acc <= w_full;
                    r_c   <= w_c_out;
                    if (w_last) begin
                        sum      <= w_full;
                        carry    <= w_c_out;
                        overflow <= w_c_out ^ w_c_top_in;
                        r_state  <= c_ST_DONE;
                    end else begin
                        r_k <= r_k + c_KW'(1);
                    end
                end
                c_ST_DONE: begin
                    if (out_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_ST_IDLE);
    assign out_valid = (r_state == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_rca_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rca_chunk_adder
// Brief    : Self-checking bench: vector table plus model-driven random ops
//            through a scoreboard on a 16/4 instance, hand sequences for
//            back-pressure, mid-run reset and an 8/8 single-chunk instance.
// Revision : 1.0  initial release
// ============================================================================
module tb_rca_chunk_adder;

    localparam int c_W = 16;
    localparam int c_N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            in_valid, in_ready, out_valid, out_ready;
    logic [c_W-1:0]  a, b, sum;
    logic            cin, sub, carry, overflow;

    logic            in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]      a8, b8, sum8;
    logic            cin8, sub8, carry8, overflow8;

    rca_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .carry(carry), .overflow(overflow)
    );

    rca_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
        .out_ready(out_ready8), .sum(sum8), .carry(carry8), .overflow(overflow8)
    );

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        res_t        exp;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    res_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent reference: widened add, overflow from operand/result signs
    function automatic res_t model(input logic [15:0] op_a, input logic [15:0] op_b,
                                   input logic c_in, input logic is_sub);
        res_t        r;
        logic [15:0] bb;
        logic        c0;
        logic [16:0] t;
        bb  = is_sub ? ~op_b : op_b;
        c0  = is_sub ? ~c_in : c_in;
        t   = {1'b0, op_a} + {1'b0, bb} + {16'd0, c0};
        r.s = t[15:0];
        r.c = t[16];
        r.v = (op_a[15] == bb[15]) && (t[15] != op_a[15]);
        return r;
    endfunction

    // Scoreboard consumer: compare each handed-off result with the oldest expectation
    always @(negedge clk) begin
        res_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_output", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_sum", {16'd0, sum}, {16'd0, e.s});
                check("sb_carry", {31'd0, carry}, {31'd0, e.c});
                check("sb_overflow", {31'd0, overflow}, {31'd0, e.v});
            end
        end
    end

    task automatic do_op(input logic [15:0] op_a, input logic [15:0] op_b,
                         input logic c_in, input logic is_sub, input res_t exp, input int stall);
        int lat;
        lat = 0;
        while (!in_ready && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        a = op_a; b = op_b; cin = c_in; sub = is_sub; in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back(exp);
        #1;
        // Garbage on the inputs while busy must be ignored
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        check("in_ready_run", {31'd0, in_ready}, 32'd0);
        check("out_valid_run", {31'd0, out_valid}, 32'd0);
        lat = 0;
        while (!out_valid && lat < c_N + 8) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", lat, c_N);
        for (int i = 0; i < stall; i++) begin
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_sum", {16'd0, sum}, {16'd0, exp.s});
            check("stall_carry", {31'd0, carry}, {31'd0, exp.c});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("release_out_valid", {31'd0, out_valid}, 32'd0);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    vec_t vecs[12];

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t v;
        res_t r;

        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}};
        vecs[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0}};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
        vecs[4]  = '{16'h1234, 16'h1111, 1'b0, 1'b0, '{16'h2345, 1'b0, 1'b0}};
        vecs[5]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, '{16'h0001, 1'b0, 1'b0}};
        vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 1'b0}};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}};
        vecs[8]  = '{16'h0005, 16'h0005, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0}};
        vecs[9]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, '{16'hFFFF, 1'b0, 1'b0}};
        vecs[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, '{16'h8000, 1'b0, 1'b1}};
        vecs[11] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, '{16'h1000, 1'b0, 1'b0}};

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_carry", {31'd0, carry}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst8_in_ready", {31'd0, in_ready8}, 32'd1);
        check("rst8_sum", {24'd0, sum8}, 32'd0);

        // Vector table, with varying back-pressure (vector 0 gets a 3-cycle stall)
        for (int i = 0; i < 12; i++) begin
            v = vecs[i];
            do_op(v.a, v.b, v.cin, v.sub, v.exp, (i == 0) ? 3 : (i % 3));
        end

        // Random operations against the reference model
        for (int i = 0; i < 10; i++) begin
            logic [15:0] ra, rb;
            logic        rc, rs;
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom);  rs = 1'($urandom);
            r  = model(ra, rb, rc, rs);
            do_op(ra, rb, rc, rs, r, i % 2);
        end

        // Leave a non-zero result with flags set, then reset in the 2nd RUN cycle
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 1'b0}, 0);
        a = 16'hAAAA; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_sum", {16'd0, sum}, 32'd0);
        check("midrst_carry", {31'd0, carry}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("midrst_no_out_valid", {31'd0, out_valid}, 32'd0);
        end
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, '{16'h2345, 1'b0, 1'b0}, 0);

        // Single-chunk instance: latency 1, carry and overflow both set
        begin
            int lat;
            a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1; sub8 = 1'b0; in_valid8 = 1'b1;
            @(posedge clk); #1;
            in_valid8 = 1'b0;
            lat = 0;
            while (!out_valid8 && lat < 10) begin
                @(posedge clk); #1; lat++;
            end
            check("w8_latency", lat, 1);
            check("w8_sum", {24'd0, sum8}, 32'h01);
            check("w8_carry", {31'd0, carry8}, 32'd1);
            check("w8_overflow", {31'd0, overflow8}, 32'd1);
            check("w8_in_ready_done", {31'd0, in_ready8}, 32'd0);
            out_ready8 = 1'b1;
            @(posedge clk); #1;
            out_ready8 = 1'b0;
            check("w8_release", {31'd0, out_valid8}, 32'd0);

            a8 = 8'h00; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b1; in_valid8 = 1'b1;
            @(posedge clk); #1;
            in_valid8 = 1'b0;
            lat = 0;
            while (!out_valid8 && lat < 10) begin
                @(posedge clk); #1; lat++;
            end
            check("w8_sub_latency", lat, 1);
            check("w8_sub_sum", {24'd0, sum8}, 32'hFF);
            check("w8_sub_carry", {31'd0, carry8}, 32'd0);
            check("w8_sub_overflow", {31'd0, overflow8}, 32'd0);
            out_ready8 = 1'b1;
            @(posedge clk); #1;
            out_ready8 = 1'b0;
        end

        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
